// File: rtl/inst_decode_reg_if.sv
// Fetch-to-decode bundle: ROM instruction and run control in, decoded fields and status out.
interface inst_decode_reg_if #(
    parameter int unsigned IW  = 9,
    parameter int unsigned PCW = 10,
    parameter int unsigned TW  = 8,
    parameter int unsigned CW  = 16
);
    logic           start;
    logic           stall;
    logic           flush;
    logic [IW-1:0]  inst_in;
    logic [PCW-1:0] prog_ctr_in;
    logic           valid;
    logic [PCW-1:0] pc_out;
    logic [2:0]     opcode;
    logic [2:0]     reg_a;
    logic [2:0]     reg_b;
    logic           branch_rel_en;
    logic [TW-1:0]  target;
    logic           done;
    logic [CW-1:0]  inst_count;

    modport master (
        output start, stall, flush, inst_in, prog_ctr_in,
        input  valid, pc_out, opcode, reg_a, reg_b, branch_rel_en, target, done, inst_count
    );

    modport slave (
        input  start, stall, flush, inst_in, prog_ctr_in,
        output valid, pc_out, opcode, reg_a, reg_b, branch_rel_en, target, done, inst_count
    );
endinterface

// File: rtl/inst_decode_reg.sv
// Decode register stage: captures ROM instruction fields each cycle and sequences idle/run/halt.
module inst_decode_reg #(
    parameter int unsigned IW  = 9,
    parameter int unsigned PCW = 10,
    parameter int unsigned TW  = 8,
    parameter int unsigned CW  = 16
) (
    input  logic               clk,
    input  logic               reset,
    inst_decode_reg_if.slave   bus
);
    localparam logic [2:0]    OP_BRANCH = 3'b111;
    localparam logic [IW-1:0] HALT_INST = IW'(9'b110_111_111);
    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            bus.valid         <= 1'b0;
            bus.branch_rel_en <= 1'b0;
            bus.done          <= 1'b0;
            bus.pc_out        <= '0;
            bus.opcode        <= '0;
            bus.reg_a         <= '0;
            bus.reg_b         <= '0;
            bus.target        <= '0;
            bus.inst_count    <= '0;
        end else if (bus.start) begin
            // Start restarts the program regardless of stall/flush
            state             <= IDLE;
            bus.valid         <= 1'b0;
            bus.branch_rel_en <= 1'b0;
            bus.done          <= 1'b0;
            bus.inst_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state             <= RUN;
                    bus.valid         <= 1'b0;
                    bus.branch_rel_en <= 1'b0;
                    bus.done          <= 1'b0;
                end
                RUN: begin
                    if (bus.flush) begin
                        bus.valid         <= 1'b0;
                        bus.branch_rel_en <= 1'b0;
                    end else if (!bus.stall) begin
                        bus.valid         <= 1'b1;
                        bus.pc_out        <= bus.prog_ctr_in;
                        bus.opcode        <= bus.inst_in[8:6];
                        bus.reg_a         <= bus.inst_in[5:3];
                        bus.reg_b         <= bus.inst_in[2:0];
                        bus.branch_rel_en <= (bus.inst_in[8:6] == OP_BRANCH);
                        bus.target        <= {{(TW-6){bus.inst_in[5]}}, bus.inst_in[5:0]};
                        if (bus.inst_count != COUNT_MAX)
                            bus.inst_count <= bus.inst_count + CW'(1);
                        if (bus.inst_in == HALT_INST)
                            state <= HALT;
                    end
                end
                HALT: begin
                    bus.done          <= 1'b1;
                    bus.valid         <= 1'b0;
                    bus.branch_rel_en <= 1'b0;
                end
                default: begin
                    state             <= IDLE;
                    bus.valid         <= 1'b0;
                    bus.branch_rel_en <= 1'b0;
                    bus.done          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/inst_decode_reg.md
Name: inst_decode_reg

Overview:
Decode pipeline stage directly downstream of the program counter / instruction ROM. Each cycle it captures the 9-bit instruction fetched at ProgCtr and registers the decoded fields. It drives BranchRelEn and Target back to the fetch stage. It also owns the run/halt sequencing per program: Start holds the stage idle, and a HALT instruction raises Done. It keeps a retired-instruction count for the bench.

Parameters:
IW, 9, instruction width (fixed ISA: [8:6] opcode, [5:3] ra, [2:0] rb).
PCW, 10, program counter width.
TW, 8, branch target width.
CW, 16, instruction counter width.

Ports:
Clk  in  1  clock; all state changes on posedge only.
Reset  in  1  synchronous, active-high; forces IDLE and clears all outputs.
Start  in  1  hold idle while high; run begins on the first cycle it is low.
Stall  in  1  hold every pipeline register and the counter.
Flush  in  1  replace the next captured instruction with a bubble.
InstIn  in  IW  instruction from the ROM at ProgCtrIn (combinational ROM).
ProgCtrIn  in  PCW  PC of InstIn.
Valid  out  1  decoded fields are a real instruction.
PCOut  out  PCW  PC of the registered instruction.
Opcode  out  3  InstIn[8:6] registered.
RegA  out  3  InstIn[5:3] registered.
RegB  out  3  InstIn[2:0] registered.
BranchRelEn  out  1  registered instruction is a branch (opcode 3'b111).
Target  out  TW  InstIn[5:0] sign-extended to TW bits, registered.
Done  out  1  program has halted.
InstCount  out  CW  number of valid instructions decoded in the current program.

Behaviour:
- Reset (sync, active-high, highest priority): state=IDLE; Valid, BranchRelEn and Done = 0; PCOut, Opcode, RegA, RegB, Target and InstCount = 0.
- FSM states:
  - IDLE: outputs are a bubble. Transition to RUN on any edge where Start=0.
  - RUN: pipeline active. Transition to HALT when a HALT instruction (9'b110_111_111) is captured with Stall=0 and Flush=0. Transition to IDLE when Start=1.
  - HALT: Done=1; Valid and BranchRelEn = 0; InstCount frozen. Transition to IDLE when Start=1.
- Start=1 in any state → IDLE at the next edge.
  - Done clears.
  - Valid clears.
  - InstCount clears to 0.
  - Start takes priority over Stall and Flush.
- Capture (RUN, Stall=0, Flush=0): at the edge, register fields of InstIn and ProgCtrIn and set Valid=1. Latency is 1 cycle from ROM output to decoded output.
- The HALT instruction itself is captured with Valid=1 and counted. The following cycle enters HALT with Valid=0.
- Stall=1 (RUN): all output registers and InstCount hold their values, including Valid and BranchRelEn.
- Flush=1 (RUN): Valid=0 and BranchRelEn=0 at the next edge; other fields don't-care (hold). Flush beats Stall when both are high, so a bubble is inserted. A HALT under Flush is ignored.
- BranchRelEn is asserted only with Valid=1. Target is valid only while BranchRelEn=1.
- Target arithmetic: Target = {{(TW-6){InstIn[5]}}, InstIn[5:0]}, range -32..+31.
- InstCount: +1 on each edge that captures with Valid set. It saturates at 2^CW-1 with no wrap. Stalled cycles, bubbles and the HALT state do not count.
- Outputs come straight from flops; there is no combinational path from inputs to outputs.
- Reset mid-run has the same effect as power-up reset. Reset while Start=0 reaches RUN two edges later (reset edge → IDLE, next edge → RUN).

Test Plan:
1. Reset=1 for 2 cycles, then Start=1 for 3 cycles, then Start=0 → all outputs 0 throughout; state goes IDLE then RUN one edge after Start falls; Valid stays 0 until the first capture.
2. RUN; InstIn = 9'b000_001_010 at PC 5, then 9'b011_100_101 at PC 6 → one cycle later Opcode=0, RegA=1, RegB=2, PCOut=5, Valid=1; next cycle Opcode=3, RegA=4, RegB=5, PCOut=6; InstCount=2.
3. Branch InstIn = 9'b111_111_110 → BranchRelEn=1 and Target=8'hFE (-2). Branch 9'b111_011_111 → Target=8'h1F.
4. Stall=1 for 3 cycles while InstIn changes → outputs and InstCount unchanged. Stall=1 and Flush=1 together with a branch on InstIn → Valid=0, BranchRelEn=0, InstCount unchanged.
5. Feed 4 normal instructions then HALT 9'b110_111_111 → InstCount=5 and Done=1 on the cycle after HALT is registered; Valid=0 after that; Done holds. Start=1 → Done=0, InstCount=0.
6. Preload the count to 16'hFFFF with CW=16 (or run with CW=4 for 20 instructions) → InstCount saturates at all-ones and does not wrap.
